alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the existing 64-bit integer ALU (add, sub, or, and; selected by funct3/funct7) between NUM_REQ requesters, e.g. the execute stage and the address-generation path.
- Round-robin arbitration with a valid/ready request channel per requester.
- One registered result slot, drained through a single tagged valid/ready response channel.
- Sits between the issue logic and the ALU; the ALU itself stays purely combinational.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), derived localparam; width of the requester tag.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_rs1  input  NUM_REQ*64  flattened operand A; slice i = bits [64*i+63:64*i].
- req_rs2  input  NUM_REQ*64  flattened operand B.
- req_funct3  input  NUM_REQ*3  flattened funct3.
- req_funct7  input  NUM_REQ*7  flattened funct7.
- resp_valid  output  1  result slot holds a result.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  64  ALU result.
- resp_id  output  ID_W  index of the requester that issued the op.
- resp_err  output  1  op was not add/sub/or/and.

Behaviour:
- Reset: a cycle with rst=1 clears resp_valid, resp_data, resp_id, resp_err and rr_ptr to 0. req_ready is forced to all-zero while rst=1. A result held at reset is discarded.
- Slot state, two states:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on pop without accept.
  - FULL to FULL on pop and accept in the same cycle.
  - FULL holds with no pop.
  - can_accept = EMPTY, or (FULL and resp_ready).
- Grant:
  - Combinational round-robin search starting at rr_ptr, wrapping NUM_REQ-1 to 0; first i with req_valid[i]=1 wins.
  - req_ready[i] = can_accept and grant[i] and not rst.
  - req_ready is high only when the transfer completes that cycle, so no grant lock is needed.
- Requester rule: once asserted, req_valid and its payload hold until accepted. The bench checks this; the RTL does not enforce it.
- Accept at edge N:
  - resp_data, resp_id and resp_err load from the granted slice through the ALU.
  - resp_valid=1 from cycle N+1. Latency is 1 cycle and throughput is 1 op/cycle when resp_ready is held high.
  - rr_ptr <= (granted index + 1) mod NUM_REQ.
  - With no accept, rr_ptr holds.
- Op decode, {funct3, funct7}:
  - 0/0x00 add, 0/0x20 sub, 6/0x00 or, 7/0x00 and.
  - Any other code: resp_err=1, resp_data=0, resp_id still valid.
- Arithmetic: 64-bit two's complement; wraps modulo 2^64; no overflow flag; carry-out unused.
- Backpressure: resp_valid, resp_data, resp_id and resp_err are stable while resp_valid=1 and resp_ready=0. No request is accepted in that state.
- Pop without accept: resp_valid drops to 0; resp_data, resp_id and resp_err hold their old values (don't-care).
- No requests and EMPTY: outputs idle; rr_ptr holds.
- All requesters valid every cycle: grants rotate 0,1,..,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 accepts.

Decomposition:
- Shared package alu_pkg holds:
  - XLEN=64.
  - funct3/funct7 constants for ADD, SUB, OR, AND.
  - A function is_legal_op(funct3, funct7).
- Sub-module rr_arbiter: purely combinational. Inputs are the request vector and pointer; outputs are a one-hot grant and the encoded index. Parameterised by NUM_REQ.
- The existing alu is instantiated once, fed by the granted slice through a NUM_REQ:1 mux.

Test Plan:
- Basic add: req0 valid, rs1=5, rs2=3, op 0/0x00, resp_ready=1 -> req_ready[0]=1 same cycle; next cycle resp_valid=1, data=8, id=0, err=0.
- Sub wrap: req1, rs1=3, rs2=5, op 0/0x20 -> data=0xFFFF_FFFF_FFFF_FFFE, id=1; rs1=0x8000_0000_0000_0000, rs2=1 sub -> 0x7FFF_FFFF_FFFF_FFFF.
- Fairness: both requesters valid continuously for 6 ops, resp_ready=1 -> resp_id sequence 0,1,0,1,0,1, one result per cycle.
- Backpressure: fill slot with or(0xF0, 0x0F)=0xFF, hold resp_ready=0 for 4 cycles with req0 valid -> req_ready=0, outputs stable at 0xFF. Raise resp_ready -> pop and accept in the same cycle, resp_valid stays 1, next result visible.
- Illegal op: funct3=1, funct7=0, rs1=rs2=7 -> resp_err=1, data=0, id correct. A subsequent and(0xC, 0xA) -> 0x8, err=0.
- Reset mid-operation: slot FULL with resp_ready=0; assert rst one cycle -> resp_valid=0, req_ready=0 that cycle, rr_ptr=0. Afterwards, both valid -> first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode fields and legality check.
// Also holds the result-slot state type used by the arbiter.
package alu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SUB = 3'd0;
    localparam logic [2:0] F3_OR  = 3'd6;
    localparam logic [2:0] F3_AND = 3'd7;

    localparam logic [6:0] F7_ADD = 7'h00;
    localparam logic [6:0] F7_SUB = 7'h20;
    localparam logic [6:0] F7_OR  = 7'h00;
    localparam logic [6:0] F7_AND = 7'h00;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic is_legal_op(
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        logic [9:0] code;
        code = {funct3, funct7};
        return (code == {F3_ADD, F7_ADD}) ||
               (code == {F3_SUB, F7_SUB}) ||
               (code == {F3_OR,  F7_OR})  ||
               (code == {F3_AND, F7_AND});
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit integer ALU: add, sub, or, and.
// Unsupported codes flag illegal and return zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    always_comb begin
        result_o  = '0;
        illegal_o = !is_legal_op(funct3_i, funct7_i);
        unique case ({funct3_i, funct7_i})
            {F3_ADD, F7_ADD}: result_o = a_i + b_i;
            {F3_SUB, F7_SUB}: result_o = a_i - b_i;
            {F3_OR,  F7_OR}:  result_o = a_i | b_i;
            {F3_AND, F7_AND}: result_o = a_i & b_i;
            default:          result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or
// after the pointer, wrapping around, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// grant and a single registered, tagged result slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*64-1:0]      req_rs1,
    input  logic [NUM_REQ*64-1:0]      req_rs2,
    input  logic [NUM_REQ*3-1:0]       req_funct3,
    input  logic [NUM_REQ*7-1:0]       req_funct7,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [63:0]                resp_data,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    slot_state_e     state_q;
    logic [XLEN-1:0] data_q;
    logic [ID_W-1:0] id_q;
    logic            err_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [2:0]      op_f3;
    logic [6:0]      op_f7;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    logic can_accept;
    logic accept;
    logic pop;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        op_a  = req_rs1[int'(gnt_idx)*XLEN +: XLEN];
        op_b  = req_rs2[int'(gnt_idx)*XLEN +: XLEN];
        op_f3 = req_funct3[int'(gnt_idx)*3 +: 3];
        op_f7 = req_funct7[int'(gnt_idx)*7 +: 7];
    end

    alu u_alu (
        .a_i       (op_a),
        .b_i       (op_b),
        .funct3_i  (op_f3),
        .funct7_i  (op_f7),
        .result_o  (alu_res),
        .illegal_o (alu_ill)
    );

    // A full slot can take a new op only in the cycle it is drained.
    assign can_accept = (state_q == SLOT_EMPTY) || resp_ready;
    assign accept     = can_accept && gnt_any && !rst;
    assign pop        = (state_q == SLOT_FULL) && resp_ready;
    assign req_ready  = accept ? gnt : '0;

    assign ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            if (accept) begin
                state_q <= SLOT_FULL;
                data_q  <= alu_res;
                id_q    <= gnt_idx;
                err_q   <= alu_ill;
                ptr_q   <= ptr_d;
            end else if (pop) begin
                state_q <= SLOT_EMPTY;
            end
        end
    end

    assign resp_valid = (state_q == SLOT_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign resp_err   = err_q;

endmodule
